cardinal_nic: RTL and testbench

CARDINAL_NIC -- requirements
Module: cardinal_nic

---
 rtl/cardinal_nic.sv | 84 ++++++++
 tb/tb_cardinal_nic.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/cardinal_nic.sv
// Cardinal NIC: one-entry input and output packet buffers between a processor
// register port and a virtual-channel router link. Bit 0 is the MSB of every data path.
module cardinal_nic #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            addr,
  input  logic [0:DATA_WIDTH-1] d_in,
  output logic [0:DATA_WIDTH-1] d_out,
  input  logic                  nicEn,
  input  logic                  nicWrEn,
  input  logic                  net_si,
  output logic                  net_ri,
  input  logic [0:DATA_WIDTH-1] net_di,
  output logic                  net_so,
  input  logic                  net_ro,
  output logic [0:DATA_WIDTH-1] net_do,
  input  logic                  net_polarity
);

  localparam logic [1:0] ADDR_IN_BUF   = 2'b00;
  localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
  localparam logic [1:0] ADDR_OUT_BUF  = 2'b10;
  localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

  logic [0:DATA_WIDTH-1] in_buf;
  logic [0:DATA_WIDTH-1] out_buf;
  logic                  in_full;
  logic                  out_full;
  logic                  rd_en;
  logic                  wr_en;
  logic                  in_take;
  logic                  out_take;

  assign rd_en    = nicEn & ~nicWrEn;
  assign wr_en    = nicEn & nicWrEn;
  assign net_ri   = ~in_full;
  // out_buf[0] carries the packet's VC; only send in the matching router phase.
  assign net_so   = out_full & (out_buf[0] == net_polarity);
  assign net_do   = out_buf;
  assign in_take  = net_si & net_ri;
  assign out_take = net_so & net_ro;

  always_comb begin
    d_out = '0;
    if (rd_en) begin
      case (addr)
        ADDR_IN_BUF:   d_out = in_buf;
        ADDR_IN_STAT:  d_out[DATA_WIDTH-1] = in_full;
        ADDR_OUT_BUF:  d_out = '0;
        ADDR_OUT_STAT: d_out[DATA_WIDTH-1] = out_full;
        default:       d_out = '0;
      endcase
    end
  end

  // A capture only happens when empty, so it never collides with a read that frees the buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_buf  <= '0;
      in_full <= 1'b0;
    end else if (in_take) begin
      in_buf  <= net_di;
      in_full <= 1'b1;
    end else if (rd_en && addr == ADDR_IN_BUF) begin
      in_full <= 1'b0;
    end
  end

  // Writes see only the pre-edge out_full, so a write racing a send is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_buf  <= '0;
      out_full <= 1'b0;
    end else if (out_take) begin
      out_full <= 1'b0;
    end else if (wr_en && addr == ADDR_OUT_BUF && !out_full) begin
      out_buf  <= d_in;
      out_full <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cardinal_nic.sv
// Self-checking bench for cardinal_nic: directed channel scenarios followed by
// randomized traffic, compared every cycle against a buffer-level reference model.
module tb_cardinal_nic;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic [63:0] d_in;
  logic [63:0] d_out;
  logic        nicEn;
  logic        nicWrEn;
  logic        net_si;
  logic        net_ri;
  logic [63:0] net_di;
  logic        net_so;
  logic        net_ro;
  logic [63:0] net_do;
  logic        net_polarity;

  int checks = 0;
  int errors = 0;

  // Reference model: one slot per direction, value plus occupancy flag.
  logic [63:0] m_in_buf, m_out_buf;
  logic        m_in_full, m_out_full;

  cardinal_nic #(.DATA_WIDTH(64)) dut (
    .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
    .nicEn(nicEn), .nicWrEn(nicWrEn), .net_si(net_si), .net_ri(net_ri),
    .net_di(net_di), .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
    .net_polarity(net_polarity)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic rst, input logic en, input logic wr, input logic [1:0] a,
                        input logic [63:0] din, input logic si, input logic [63:0] di,
                        input logic ro, input logic pol);
    reset = rst; nicEn = en; nicWrEn = wr; addr = a; d_in = din;
    net_si = si; net_di = di; net_ro = ro; net_polarity = pol;
  endtask

  // Compare outputs against the model, then advance model and DUT by one edge.
  task automatic step();
    logic [63:0] exp_dout;
    logic        exp_so, sent, took;
    #1;
    exp_dout = 64'h0;
    if (nicEn && !nicWrEn) begin
      if (addr == 2'd0)      exp_dout = m_in_buf;
      else if (addr == 2'd1) exp_dout = m_in_full ? 64'h1 : 64'h0;
      else if (addr == 2'd3) exp_dout = m_out_full ? 64'h1 : 64'h0;
    end
    exp_so = m_out_full && (m_out_buf[63] == net_polarity);
    check("d_out", d_out, exp_dout);
    check("net_ri", {63'h0, net_ri}, {63'h0, !m_in_full});
    check("net_so", {63'h0, net_so}, {63'h0, exp_so});
    check("net_do", net_do, m_out_buf);
    took = net_si && !m_in_full;
    sent = exp_so && net_ro;
    @(posedge clk);
    if (reset) begin
      m_in_buf = 0; m_in_full = 0; m_out_buf = 0; m_out_full = 0;
    end else begin
      if (took) begin
        m_in_buf = net_di; m_in_full = 1;
      end else if (nicEn && !nicWrEn && addr == 2'd0) begin
        m_in_full = 0;
      end
      if (sent) m_out_full = 0;
      else if (nicEn && nicWrEn && addr == 2'd2 && !m_out_full) begin
        m_out_buf = d_in; m_out_full = 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic pol);
    set_in(0, 0, 0, 2'd0, 64'h0, 0, 64'h0, 0, pol);
  endtask

  initial begin
    set_in(1, 0, 0, 2'd0, 64'h0, 0, 64'h0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    m_in_buf = 0; m_in_full = 0; m_out_buf = 0; m_out_full = 0;

    // Post-reset state
    idle(0); #1;
    check("rst_ri", {63'h0, net_ri}, 64'h1);
    check("rst_so", {63'h0, net_so}, 64'h0);
    check("rst_do", net_do, 64'h0);
    check("rst_dout", d_out, 64'h0);
    step();

    // Router delivers one packet
    set_in(0, 0, 0, 2'd0, 64'h0, 1, 64'hA5A5_0000_0000_0001, 0, 0); step();
    set_in(0, 1, 0, 2'd1, 64'h0, 0, 64'h0, 0, 0); #1;
    check("in_stat_full", d_out, 64'h1);
    check("ri_full", {63'h0, net_ri}, 64'h0);
    step();
    // Read buffer while a new packet waits: capture only on the following edge
    set_in(0, 1, 0, 2'd0, 64'h0, 1, 64'h0BAD_0000_0000_0002, 0, 0); #1;
    check("in_buf_read", d_out, 64'hA5A5_0000_0000_0001);
    step();
    set_in(0, 1, 0, 2'd1, 64'h0, 1, 64'h0BAD_0000_0000_0002, 0, 0); #1;
    check("in_freed", d_out, 64'h0);
    step();
    set_in(0, 1, 0, 2'd0, 64'h0, 0, 64'h0, 0, 0); #1;
    check("in_second", d_out, 64'h0BAD_0000_0000_0002);
    step();

    // Output write in wrong phase, then send in matching phase
    set_in(0, 1, 1, 2'd2, 64'h8000_0000_0000_00FF, 0, 64'h0, 0, 0); step();
    idle(0); #1;
    check("so_wrong_phase", {63'h0, net_so}, 64'h0);
    step();
    // Write while full is dropped
    set_in(0, 1, 1, 2'd2, 64'h1234, 0, 64'h0, 0, 0); step();
    idle(1); #1;
    check("drop_full", net_do, 64'h8000_0000_0000_00FF);
    step();
    // Router stalls for 10 cycles
    for (int i = 0; i < 10; i++) begin
      idle(1); #1;
      check("stall_so", {63'h0, net_so}, 64'h1);
      check("stall_do", net_do, 64'h8000_0000_0000_00FF);
      step();
    end
    // Write on the same edge as the transfer is dropped
    set_in(0, 1, 1, 2'd2, 64'h1234, 0, 64'h0, 1, 1); step();
    set_in(0, 1, 0, 2'd3, 64'h0, 0, 64'h0, 1, 1); #1;
    check("race_stat", d_out, 64'h0);
    check("race_so", {63'h0, net_so}, 64'h0);
    step();

    // Reset with both buffers full
    set_in(0, 1, 1, 2'd2, 64'h0000_0000_0000_0077, 1, 64'h55, 0, 1); step();
    set_in(1, 0, 0, 2'd0, 64'h0, 1, 64'h99, 1, 0); step();
    set_in(0, 1, 0, 2'd1, 64'h0, 0, 64'h0, 0, 0); #1;
    check("rst2_in_stat", d_out, 64'h0);
    check("rst2_ri", {63'h0, net_ri}, 64'h1);
    check("rst2_so", {63'h0, net_so}, 64'h0);
    step();
    set_in(0, 1, 0, 2'd3, 64'h0, 0, 64'h0, 0, 0); #1;
    check("rst2_out_stat", d_out, 64'h0);
    step();

    // Randomized traffic on both channels
    for (int i = 0; i < 600; i++) begin
      set_in($urandom_range(0, 59) == 0,
             $urandom_range(0, 3) != 0,
             $urandom_range(0, 1),
             2'($urandom_range(0, 3)),
             {$urandom, $urandom},
             $urandom_range(0, 1),
             {$urandom, $urandom},
             $urandom_range(0, 2) != 0,
             $urandom_range(0, 1));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
